// File: rtl/dmem_access_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dmem_access_arbiter_pkg
// Brief   : Shared state encoding and default sizes for the data-memory arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package dmem_access_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_FLUSH = 2'd2
  } arb_state_t;

  localparam int c_ADDR_W_DEFAULT       = 5;
  localparam int c_LEN_W_DEFAULT        = 6;
  localparam int c_STARVE_LIMIT_DEFAULT = 4;
  localparam int c_STARVE_W             = 4;

endpackage
`default_nettype wire

// File: rtl/dmem_starve_counter.sv
`default_nettype none
// ============================================================================
// Module  : dmem_starve_counter
// Brief   : Saturating count of contested cycles the CPU has won in a row.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_starve_counter
  import dmem_access_arbiter_pkg::*;
#(
  parameter int LIMIT = c_STARVE_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  logic [c_STARVE_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + c_STARVE_W'(1);
    end
  end

  assign at_limit = (r_count == c_STARVE_W'(LIMIT));

endmodule
`default_nettype wire

// File: rtl/dmem_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dmem_access_arbiter
// Brief   : Shares the single-port data memory between the MEM stage and a
//           DMA burst port; CPU has priority, bounded by a starvation limit.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_access_arbiter
  import dmem_access_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = c_STARVE_LIMIT_DEFAULT,
  parameter int ADDR_W       = c_ADDR_W_DEFAULT,
  parameter int LEN_W        = c_LEN_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [LEN_W-1:0]  dma_len,
  input  logic [31:0]       dma_wdata,
  output logic              dma_ack,
  output logic [31:0]       dma_rdata,
  output logic              dma_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  arb_state_t        r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [LEN_W-1:0]  r_remain;
  logic              r_we;
  logic              r_done;

  logic w_in_burst;
  logic w_at_limit;
  logic w_dma_grant;
  logic w_cpu_grant;
  logic w_starve_inc;
  logic w_starve_clr;
  logic w_last_beat;

  assign w_in_burst   = (r_state == ST_BURST);
  assign w_dma_grant  = w_in_burst && (!cpu_req || w_at_limit);
  assign w_cpu_grant  = cpu_req && !w_dma_grant;
  assign w_starve_inc = w_in_burst && cpu_req && !w_at_limit;
  // Any DMA beat (forced or uncontested) and any non-burst cycle resets fairness.
  assign w_starve_clr = w_dma_grant || !w_in_burst;
  assign w_last_beat  = (r_remain == LEN_W'(1));

  dmem_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc      (w_starve_inc),
    .clr      (w_starve_clr),
    .at_limit (w_at_limit)
  );

  always_comb begin
    mem_addr  = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_wdata = '0;
    if (w_dma_grant) begin
      mem_addr  = r_ptr;
      mem_read  = !r_we;
      mem_write = r_we;
      mem_wdata = dma_wdata;
    end else if (w_cpu_grant) begin
      mem_addr  = cpu_addr;
      mem_read  = !cpu_we;
      mem_write = cpu_we;
      mem_wdata = cpu_wdata;
    end
  end

  assign cpu_stall = w_dma_grant && cpu_req;
  assign cpu_rdata = w_cpu_grant ? mem_rdata : '0;
  assign dma_ack   = w_dma_grant;
  assign dma_rdata = w_dma_grant ? mem_rdata : '0;
  assign dma_done  = r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_remain <= '0;
      r_we     <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (dma_req) begin
            if (dma_len != '0) begin
              r_ptr    <= dma_addr;
              r_remain <= dma_len;
              r_we     <= dma_we;
              r_state  <= ST_BURST;
            end else begin
              r_state <= ST_FLUSH;
              r_done  <= 1'b1;
            end
          end
        end
        ST_BURST: begin
          if (w_dma_grant) begin
            r_ptr    <= r_ptr + ADDR_W'(1);
            r_remain <= r_remain - LEN_W'(1);
            if (w_last_beat) begin
              r_state <= ST_FLUSH;
              r_done  <= 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_access_arbiter
// Brief   : Scoreboard bench for dmem_access_arbiter with a behavioural memory.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dmem_access_arbiter;

  localparam logic [31:0] c_SEED = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [4:0]  cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_we;
  logic [4:0]  dma_addr;
  logic [5:0]  dma_len;
  logic [31:0] dma_wdata, dma_rdata;
  logic        dma_ack, dma_done;
  logic [4:0]  mem_addr;
  logic        mem_read, mem_write;
  logic [31:0] mem_wdata, mem_rdata;

  dmem_access_arbiter #(
    .STARVE_LIMIT (4),
    .ADDR_W       (5),
    .LEN_W        (6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_len   (dma_len),
    .dma_wdata (dma_wdata),
    .dma_ack   (dma_ack),
    .dma_rdata (dma_rdata),
    .dma_done  (dma_done),
    .mem_addr  (mem_addr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 32x32 memory with combinational read.
  logic [31:0] tb_mem [32];
  logic        mem_init;
  assign mem_rdata = tb_mem[mem_addr];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) tb_mem[i] <= 32'h1000_0000 + 32'(i);
    end else if (mem_write) begin
      tb_mem[mem_addr] <= mem_wdata;
    end
  end

  typedef struct {
    int          cyc;
    logic [4:0]  addr;
    logic        we;
    logic [31:0] data;
  } beat_t;

  beat_t       bq[$];
  int          dq[$];
  logic [31:0] exp_mem [32];
  int          cyc;
  int          beat_cnt;
  int          n_pushed;
  int          n_checks;
  int          n_fails;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    dma_wdata = c_SEED + 32'(beat_cnt);
  endtask

  task automatic push_beat(input int c, input logic [4:0] a, input logic w);
    beat_t b;
    b.cyc  = c;
    b.addr = a;
    b.we   = w;
    if (w) begin
      b.data     = c_SEED + 32'(n_pushed);
      exp_mem[a] = b.data;
    end else begin
      b.data = exp_mem[a];
    end
    n_pushed++;
    bq.push_back(b);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk_eq({tag, "_stall"}, 32'(cpu_stall), 32'd0);
    chk_eq({tag, "_ack"},   32'(dma_ack),   32'd0);
    chk_eq({tag, "_done"},  32'(dma_done),  32'd0);
    chk_eq({tag, "_rd"},    32'(mem_read),  32'd0);
    chk_eq({tag, "_wr"},    32'(mem_write), 32'd0);
    chk_eq({tag, "_addr"},  32'(mem_addr),  32'd0);
    chk_eq({tag, "_wdata"}, mem_wdata,      32'd0);
  endtask

  task automatic chk_drained(input string tag);
    chk_eq({tag, "_beats_left"}, 32'(bq.size()), 32'd0);
    chk_eq({tag, "_done_left"},  32'(dq.size()), 32'd0);
  endtask

  // Scoreboard side: every DMA beat and done pulse is matched to its expectation.
  always @(negedge clk) begin
    beat_t b;
    int    dc;
    chk_eq("rd_wr_exclusive", 32'(mem_read & mem_write), 32'd0);
    if (dma_ack) begin
      if (bq.size() == 0) begin
        chk_eq("ack_unexpected", 32'(dma_ack), 32'd0);
      end else begin
        b = bq.pop_front();
        chk_eq("beat_cycle", 32'(cyc), 32'(b.cyc));
        chk_eq("beat_addr",  32'(mem_addr), 32'(b.addr));
        chk_eq("beat_write", 32'(mem_write), 32'(b.we));
        chk_eq("beat_read",  32'(mem_read), 32'(!b.we));
        if (b.we) chk_eq("beat_wdata", mem_wdata, b.data);
        else      chk_eq("beat_rdata", dma_rdata, b.data);
      end
      beat_cnt++;
    end
    if (dma_done) begin
      if (dq.size() == 0) begin
        chk_eq("done_unexpected", 32'(dma_done), 32'd0);
      end else begin
        dc = dq.pop_front();
        chk_eq("done_cycle", 32'(cyc), 32'(dc));
      end
    end
  end

  initial begin
    int          c0;
    logic [4:0]  rb_addr [4];
    cyc = 0; beat_cnt = 0; n_pushed = 0; n_checks = 0; n_fails = 0;
    rst = 1'b1; mem_init = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_len = '0; dma_wdata = '0;
    for (int i = 0; i < 32; i++) exp_mem[i] = 32'h1000_0000 + 32'(i);

    // Reset and idle
    tick(); tick();
    #1 chk_idle_outputs("reset");
    tick(); rst = 1'b0; mem_init = 1'b0;
    tick();
    #1 chk_idle_outputs("idle");

    // DMA write burst, wraps 31 -> 0
    tick(); c0 = cyc;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 5'd30; dma_len = 6'd4;
    push_beat(c0 + 1, 5'd30, 1'b1); push_beat(c0 + 2, 5'd31, 1'b1);
    push_beat(c0 + 3, 5'd0, 1'b1);  push_beat(c0 + 4, 5'd1, 1'b1);
    dq.push_back(c0 + 5);
    #1 chk_eq("req_cycle_no_ack", 32'(dma_ack), 32'd0);
    tick(); dma_req = 1'b0; dma_addr = 5'd7; dma_len = 6'd9;
    repeat (5) tick();
    chk_drained("wr_burst");

    rb_addr[0] = 5'd30; rb_addr[1] = 5'd31; rb_addr[2] = 5'd0; rb_addr[3] = 5'd1;
    for (int i = 0; i < 4; i++) begin
      tick(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = rb_addr[i];
      #1;
      chk_eq("readback_data",  cpu_rdata, exp_mem[rb_addr[i]]);
      chk_eq("readback_stall", 32'(cpu_stall), 32'd0);
    end
    tick(); cpu_req = 1'b0;

    // Contested read burst: CPU loads every cycle
    tick(); c0 = cyc;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 5'd30; dma_len = 6'd2;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd5;
    push_beat(c0 + 5, 5'd30, 1'b0); push_beat(c0 + 10, 5'd31, 1'b0);
    dq.push_back(c0 + 11);
    for (int k = 1; k <= 11; k++) begin
      tick(); dma_req = 1'b0;
      #1;
      chk_eq("contend_stall", 32'(cpu_stall), 32'((k == 5) || (k == 10)));
      if (!cpu_stall) chk_eq("contend_cpu_rdata", cpu_rdata, exp_mem[5]);
    end
    tick(); cpu_req = 1'b0;
    tick();
    chk_drained("contend");

    // Empty burst
    tick(); c0 = cyc;
    dma_req = 1'b1; dma_we = 1'b1; dma_len = 6'd0;
    dq.push_back(c0 + 1);
    #1 chk_eq("empty_req_wr", 32'(mem_write), 32'd0);
    tick(); dma_req = 1'b0;
    #1;
    chk_eq("empty_flush_wr", 32'(mem_write), 32'd0);
    chk_eq("empty_flush_rd", 32'(mem_read), 32'd0);
    tick(); tick();
    chk_drained("empty");

    // Back-to-back bursts with dma_req held; mid-burst address change ignored
    tick(); c0 = cyc;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 5'd3; dma_len = 6'd2;
    push_beat(c0 + 1, 5'd3, 1'b1);  push_beat(c0 + 2, 5'd4, 1'b1);
    dq.push_back(c0 + 3);
    push_beat(c0 + 5, 5'd20, 1'b1); push_beat(c0 + 6, 5'd21, 1'b1);
    dq.push_back(c0 + 7);
    tick(); dma_addr = 5'd20;
    repeat (5) tick();
    tick(); dma_req = 1'b0;
    tick(); tick();
    chk_drained("b2b");

    // Uncontested CPU store during a burst does not advance the pointer
    tick(); c0 = cyc;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 5'd8; dma_len = 6'd3;
    push_beat(c0 + 2, 5'd8, 1'b0); push_beat(c0 + 3, 5'd9, 1'b0);
    push_beat(c0 + 4, 5'd10, 1'b0);
    dq.push_back(c0 + 5);
    tick(); dma_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd12; cpu_wdata = 32'hCAFE_0012;
    exp_mem[12] = 32'hCAFE_0012;
    #1;
    chk_eq("store_wr",    32'(mem_write), 32'd1);
    chk_eq("store_addr",  32'(mem_addr), 32'd12);
    chk_eq("store_wdata", mem_wdata, 32'hCAFE_0012);
    chk_eq("store_stall", 32'(cpu_stall), 32'd0);
    chk_eq("store_ack",   32'(dma_ack), 32'd0);
    tick(); cpu_req = 1'b0; cpu_we = 1'b0;
    #1 chk_eq("ptr_held_addr", 32'(mem_addr), 32'd8);
    repeat (4) tick();
    chk_drained("store");
    tick(); cpu_req = 1'b1; cpu_addr = 5'd12;
    #1 chk_eq("store_readback", cpu_rdata, exp_mem[12]);
    tick(); cpu_req = 1'b0;

    // Reset mid-burst aborts with no done pulse
    tick(); c0 = cyc;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 5'd2; dma_len = 6'd5;
    push_beat(c0 + 1, 5'd2, 1'b0); push_beat(c0 + 2, 5'd3, 1'b0);
    tick(); dma_req = 1'b0;
    tick();
    tick(); rst = 1'b1;
    #1;
    chk_eq("rst_ack",  32'(dma_ack), 32'd0);
    chk_eq("rst_done", 32'(dma_done), 32'd0);
    chk_eq("rst_rd",   32'(mem_read), 32'd0);
    tick(); rst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd4;
    for (int k = 0; k < 6; k++) begin
      tick();
      #1 chk_eq("post_rst_stall", 32'(cpu_stall), 32'd0);
    end
    tick(); cpu_req = 1'b0;
    tick();
    chk_drained("rst_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_access_arbiter.md
Name: dmem_access_arbiter

Overview:
- Shares the single-port 32x32 data memory between the pipeline MEM stage (CPU port) and a block-transfer port (DMA port) used for program loading and test-data readback.
- Sits between the MEM stage and the data memory. It drives the memory's addr/MemRead/MemWrite/Write_Data and stalls the pipeline when the DMA port takes a cycle.
- CPU has priority. A starvation counter guarantees forward progress for DMA bursts.

Parameters:
- STARVE_LIMIT, 4: consecutive contested cycles the CPU may win before DMA is forced one beat (legal range 1..15).
- ADDR_W, 5: memory word-address width; addresses wrap modulo 2^ADDR_W.
- LEN_W, 6: burst-length field width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  MEM stage has a load/store this cycle.
- cpu_we  in  1  1=store, 0=load.
- cpu_addr  in  ADDR_W  word address.
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data; valid when cpu_req=1 and cpu_stall=0.
- cpu_stall  out  1  hold the pipeline; the CPU access was not performed.
- dma_req  in  1  start-burst request; sampled only in IDLE.
- dma_we  in  1  burst direction (1=write memory); latched at start.
- dma_addr  in  ADDR_W  burst base address; latched at start.
- dma_len  in  LEN_W  beat count; latched at start; 0 = empty burst.
- dma_wdata  in  32  write data for the current beat.
- dma_ack  out  1  current beat performed this cycle; the requester advances its data.
- dma_rdata  out  32  read data; valid when dma_ack=1.
- dma_done  out  1  one-cycle pulse when the burst has completed.
- mem_addr  out  ADDR_W  to memory addr.
- mem_read  out  1  to memory MemRead.
- mem_write  out  1  to memory MemWrite.
- mem_wdata  out  32  to memory Write_Data.
- mem_rdata  in  32  from memory Read_Data (combinational read).

Behaviour:
- States: IDLE, BURST, FLUSH. Registers:
  - base/pointer address (ADDR_W)
  - beats-remaining (LEN_W)
  - latched dma_we
  - starve counter (4 bits)
  - dma_done flop
- Reset (async):
  - state=IDLE, counters=0, dma_done=0.
  - The combinational outputs then evaluate to cpu_stall=0, dma_ack=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
- IDLE:
  - If dma_req=1 and dma_len!=0: latch addr/len/we, go to BURST next cycle.
  - If dma_req=1 and dma_len=0: go to FLUSH.
  - No DMA access occurs in the IDLE cycle itself.
- Grant in BURST (combinational, same cycle):
  - If cpu_req=0, DMA is granted.
  - If cpu_req=1 and starve<STARVE_LIMIT, CPU is granted and starve increments.
  - If cpu_req=1 and starve==STARVE_LIMIT, DMA is granted, cpu_stall=1, and starve clears.
  - Starve clears on any uncontested DMA beat and on leaving BURST.
- Grant in IDLE and FLUSH: always CPU; cpu_stall=0.
- CPU grant: mem_addr=cpu_addr, mem_read=cpu_req&~cpu_we, mem_write=cpu_req&cpu_we, mem_wdata=cpu_wdata.
- DMA grant:
  - mem_addr=pointer, mem_read=~we_l, mem_write=we_l, mem_wdata=dma_wdata, dma_ack=1.
  - On the edge: pointer+1 (wraps 31 to 0), remaining-1.
  - Beat with remaining==1 goes to FLUSH.
- mem_read and mem_write are never both 1, and both are 0 when no access is granted.
- FLUSH lasts one cycle: dma_done=1, then IDLE. dma_req is ignored in FLUSH; the earliest restart is sampled in the following IDLE cycle.
- cpu_rdata and dma_rdata are both wired to mem_rdata; qualify them with the grant/ack signals.
- Latency:
  - CPU uncontested: 0 added cycles.
  - DMA burst of N beats with no CPU traffic: request at T, beats T+1..T+N, done at T+N+1.
- dma_req, dma_addr, dma_len and dma_we changes during BURST are ignored.
- Lengths above 32 are legal and re-visit wrapped addresses.
- rst mid-burst: aborts immediately, no dma_done, memory contents untouched by the arbiter.

Decomposition:
- Shared package:
  - state encoding (IDLE=2'd0, BURST=2'd1, FLUSH=2'd2)
  - ADDR_W/LEN_W defaults
  - STARVE_LIMIT default
- One natural sub-module, dmem_starve_counter: saturating contested-cycle counter with inc/clear inputs and an at_limit output.
- Grant mux and FSM stay in the top.

Test Plan:
- Reset then idle, cpu_req=0 -> all outputs 0; assert rst mid-burst -> dma_ack/dma_done stay 0, state IDLE.
- DMA write burst, addr=30, len=4, cpu idle -> dma_ack on 4 consecutive cycles, mem_addr 30,31,0,1, mem_write=1, dma_done one cycle later; readback shows the written words.
- CPU load every cycle during a DMA read burst, len=2, STARVE_LIMIT=4 -> CPU wins 4 cycles, 5th cycle cpu_stall=1 and dma_ack=1; repeats; dma_done after 2 beats at cycle 11.
- dma_len=0 -> no mem access, dma_done pulses one cycle after the request, then back to IDLE.
- Back-to-back bursts, dma_req held high -> second burst latches in the IDLE cycle following the dma_done pulse; dma_addr change mid-burst has no effect.
- CPU store addr=12 uncontested during BURST -> mem_write=1, mem_addr=12, cpu_stall=0, no dma_ack that cycle; the DMA pointer is not advanced.
